// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipelined CPU stage registers: hazard-unit
// condition codes, skid FSM state encodings and per-stage widths.
// The skid entry itself is selected with the PIPE_SKID_EN macro in pipe_stage_reg.
package pipe_pkg;

  // Hazard-unit commands; code 3 is reserved and behaves like HOLD
  localparam logic [1:0] COND_FLUSH = 2'd0;
  localparam logic [1:0] COND_LOAD  = 2'd1;
  localparam logic [1:0] COND_HOLD  = 2'd2;

  // Occupancy of the two-entry (skid) stage
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Per-stage control/payload widths
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 133;
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  // HOLD and the reserved code both have the upper bit set
  function automatic logic cond_is_hold(input logic [1:0] cond);
    return cond[1];
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between a pipeline stage register and its
// neighbours. master drives the upstream beat and downstream ready,
// slave is the stage register itself.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 101,
  parameter int CNT_W  = 16
);
  logic [1:0]        cond;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  hold_cnt;

  modport master (
    output cond, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, hold_cnt
  );

  modport slave (
    input  cond, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, hold_cnt
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage's hold-cycle statistic.
// Sticks at all-ones instead of wrapping; clr is a synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a
// valid/ready handshake steered by the hazard unit (FLUSH/LOAD/HOLD).
// Macro PIPE_SKID_EN: when defined the stage holds two entries and in_ready
// is taken from a flop; when undefined it is a single entry with a
// combinational ready path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int DATA_W     = 101,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_stage_reg_if.slave  bus
);

  logic              load;
  logic              flush;
  logic              hold;
  logic              accept;
  logic              consume;
  logic              valid_int;
  logic              in_ready_int;

  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] ctrl_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  assign load    = (bus.cond == COND_LOAD);
  assign flush   = (bus.cond == COND_FLUSH);
  assign hold    = cond_is_hold(bus.cond);
  assign accept  = load && bus.in_valid && in_ready_int;
  assign consume = load && valid_int && bus.out_ready;

`ifdef PIPE_SKID_EN

  skid_state_e       state_q;
  skid_state_e       state_d;
  logic              ready_q;
  logic              ready_d;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;

  // State register; ready_q mirrors "not full" so in_ready has no comb path from out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: flush empties, hold freezes, load tracks accepts against consumes
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (load) begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !consume) begin
            state_d = ST_TWO;
          end else if (consume && !accept) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO:   if (consume) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
    ready_d = (state_d != ST_TWO);
  end

  // Outputs decoded from the registered state only
  always_comb begin
    in_ready_int = flush || (load && ready_q);
    valid_int    = (state_q != ST_EMPTY);
  end

  // Head/skid datapath: a parked beat moves to the head when the head is consumed
  always_comb begin
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      ctrl_d = '0;
      if (CLEAR_DATA) begin
        data_d = '0;
      end
    end else if (load) begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            ctrl_d = bus.in_ctrl;
            data_d = bus.in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            ctrl_d = bus.in_ctrl;
            data_d = bus.in_data;
          end else if (accept) begin
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
          end
        end
        ST_TWO: begin
          if (consume) begin
            ctrl_d = skid_ctrl_q;
            data_d = skid_data_q;
          end
        end
        default: begin
          ctrl_d = ctrl_q;
        end
      endcase
    end
  end

  // Skid entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`else

  logic valid_q;
  logic valid_d;

  assign in_ready_int = flush || (load && (!valid_q || bus.out_ready));
  assign valid_int    = valid_q;

  // Single entry: accept replaces the head, a lone consume drops valid only
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLEAR_DATA) begin
        data_d = '0;
      end
    end else if (load) begin
      if (accept) begin
        valid_d = 1'b1;
        ctrl_d  = bus.in_ctrl;
        data_d  = bus.in_data;
      end else if (consume) begin
        valid_d = 1'b0;
      end
    end
  end

  // Valid bit of the single entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

`endif

  // Head control and payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hold),
    .clr (1'b0),
    .q   (bus.hold_cnt)
  );

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = valid_int && !hold;
  assign bus.out_ctrl  = ctrl_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a queue-based occupancy model
// predicts handshakes and register contents, a scoreboard checks beat order.
// A second instance (CLEAR_DATA=0, CNT_W=3) shares the stimulus.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CTRL_W = 4;
  localparam int DATA_W = 101;
  localparam int CNT_W  = 16;
  localparam int CNT2_W = 3;
`ifdef PIPE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W))  bus ();
  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT2_W)) bus2 ();

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b1), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b0), .CNT_W(CNT2_W)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.cond      = bus.cond;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_ctrl   = bus.in_ctrl;
  assign bus2.in_data   = bus.in_data;
  assign bus2.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t             model_q[$];
  beat_t             sb_q[$];
  logic [CTRL_W-1:0] hv_ctrl;
  logic [DATA_W-1:0] hv_data1;
  logic [DATA_W-1:0] hv_data2;
  int unsigned       hold_model;

  logic              mon_en = 1'b0;
  logic              exp_in_ready;
  logic              exp_out_valid;
  logic              exp_chk_valid;
  logic [CTRL_W-1:0] exp_ctrl;
  logic [DATA_W-1:0] exp_data1;
  logic [DATA_W-1:0] exp_data2;
  int unsigned       exp_hold1;
  int unsigned       exp_hold2;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned max);
    return (v > max) ? max : v;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  function automatic logic [CTRL_W-1:0] rand_ctrl();
    logic [31:0] r;
    r = $urandom();
    return r[CTRL_W-1:0];
  endfunction

  task automatic resetModel();
    model_q.delete();
    sb_q.delete();
    hv_ctrl    = '0;
    hv_data1   = '0;
    hv_data2   = '0;
    hold_model = 0;
  endtask

  // One clock cycle: drive inputs, publish expectations for this cycle, advance the model
  task automatic applyStimulus(input logic [1:0] c, input logic iv, input logic [CTRL_W-1:0] ictrl,
                               input logic [DATA_W-1:0] idata, input logic ordy, output logic acc);
    logic  load;
    logic  cons;
    beat_t b;
    @(posedge clk);
    #1;
    bus.cond      = c;
    bus.in_valid  = iv;
    bus.in_ctrl   = ictrl;
    bus.in_data   = idata;
    bus.out_ready = ordy;
    load = (c == COND_LOAD);
    exp_in_ready  = (c == COND_FLUSH) ||
                    (load && ((DEPTH == 2) ? (model_q.size() < 2) : ((model_q.size() == 0) || ordy)));
    exp_out_valid = (model_q.size() != 0) && load;
    exp_chk_valid = (c != COND_FLUSH);
    exp_ctrl      = hv_ctrl;
    exp_data1     = hv_data1;
    exp_data2     = hv_data2;
    exp_hold1     = sat(hold_model, (1 << CNT_W) - 1);
    exp_hold2     = sat(hold_model, (1 << CNT2_W) - 1);
    acc  = load && iv && exp_in_ready;
    cons = load && (model_q.size() != 0) && ordy;
    b.ctrl = ictrl;
    b.data = idata;
    if (c == COND_FLUSH) begin
      model_q.delete();
      sb_q.delete();
      hv_ctrl  = '0;
      hv_data1 = '0;
    end else if (load) begin
      if (cons) void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back(b);
        sb_q.push_back(b);
      end
    end else begin
      hold_model++;
    end
    if ((c != COND_FLUSH) && (model_q.size() != 0)) begin
      hv_ctrl  = model_q[0].ctrl;
      hv_data1 = model_q[0].data;
      hv_data2 = model_q[0].data;
    end
    mon_en = 1'b1;
  endtask

  // Monitor: compare handshake/register outputs and pop the scoreboard on every consume
  always @(negedge clk) begin
    if (mon_en) begin
      beat_t b;
      if (exp_chk_valid) begin
        checkOutput("out_valid", 128'(bus.out_valid), 128'(exp_out_valid));
        checkOutput("out_valid_2", 128'(bus2.out_valid), 128'(exp_out_valid));
      end
      checkOutput("in_ready", 128'(bus.in_ready), 128'(exp_in_ready));
      checkOutput("in_ready_2", 128'(bus2.in_ready), 128'(exp_in_ready));
      checkOutput("out_ctrl", 128'(bus.out_ctrl), 128'(exp_ctrl));
      checkOutput("out_ctrl_2", 128'(bus2.out_ctrl), 128'(exp_ctrl));
      checkOutput("out_data", 128'(bus.out_data), 128'(exp_data1));
      checkOutput("out_data_2", 128'(bus2.out_data), 128'(exp_data2));
      checkOutput("hold_cnt", 128'(bus.hold_cnt), 128'(exp_hold1));
      checkOutput("hold_cnt_2", 128'(bus2.hold_cnt), 128'(exp_hold2));
      if (bus.out_valid && bus.out_ready && (bus.cond == COND_LOAD)) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected_beat", 128'(1), 128'(0));
        end else begin
          b = sb_q.pop_front();
          checkOutput("sb_ctrl", 128'(bus.out_ctrl), 128'(b.ctrl));
          checkOutput("sb_data", 128'(bus.out_data), 128'(b.data));
        end
      end
    end
  end

  initial begin
    logic                acc;
    int                  idx;
    logic [DATA_W-1:0]   skid_vals [3];
    logic [1:0]          c;
    int                  r;

    bus.cond      = COND_LOAD;
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    resetModel();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("rst_out_ctrl", 128'(bus.out_ctrl), 128'(0));
    checkOutput("rst_out_data", 128'(bus.out_data), 128'(0));
    checkOutput("rst_hold_cnt", 128'(bus.hold_cnt), 128'(0));
    rst = 1'b0;

    // Back-to-back streaming 0x1..0x8
    for (int i = 1; i <= 8; i++) applyStimulus(COND_LOAD, 1'b1, rand_ctrl(), DATA_W'(i), 1'b1, acc);
    applyStimulus(COND_LOAD, 1'b0, '0, '0, 1'b1, acc);

    // Flush a live beat while an input beat is offered
    applyStimulus(COND_LOAD, 1'b1, 4'hF, DATA_W'(32'hABCD), 1'b0, acc);
    applyStimulus(COND_FLUSH, 1'b1, 4'h3, DATA_W'(32'h5555), 1'b0, acc);
    applyStimulus(COND_LOAD, 1'b0, '0, '0, 1'b0, acc);
    checkOutput("flush_ctrl", 128'(bus.out_ctrl), 128'(0));
    checkOutput("flush_data_clear", 128'(bus.out_data), 128'(0));
    checkOutput("flush_data_held", 128'(bus2.out_data), 128'(32'hABCD));

    // Five HOLD cycles (one using the reserved code) with a beat inside
    applyStimulus(COND_LOAD, 1'b1, rand_ctrl(), DATA_W'(32'h77), 1'b0, acc);
    for (int i = 0; i < 5; i++)
      applyStimulus((i == 2) ? 2'd3 : COND_HOLD, 1'b1, rand_ctrl(), rand_data(), 1'b1, acc);
    applyStimulus(COND_LOAD, 1'b0, '0, '0, 1'b1, acc);
    checkOutput("hold_cnt_after_5", 128'(bus.hold_cnt), 128'(5));

    // Saturation of the 3-bit counter
    for (int i = 0; i < 10; i++) applyStimulus(COND_HOLD, 1'b0, '0, '0, 1'b0, acc);
    applyStimulus(COND_LOAD, 1'b0, '0, '0, 1'b0, acc);
    checkOutput("hold_cnt_sat3", 128'(bus2.hold_cnt), 128'(7));
    checkOutput("hold_cnt_15", 128'(bus.hold_cnt), 128'(15));

    // Back-pressure: offer 0x11, 0x22, 0x33 with downstream stalled, then release
    skid_vals[0] = DATA_W'(32'h11);
    skid_vals[1] = DATA_W'(32'h22);
    skid_vals[2] = DATA_W'(32'h33);
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(COND_LOAD, 1'b1, rand_ctrl(), skid_vals[idx], 1'b0, acc);
      if (acc) idx++;
    end
    checkOutput("stall_accepted", 128'(idx), 128'(DEPTH));
    for (int i = 0; i < 10 && idx < 3; i++) begin
      applyStimulus(COND_LOAD, 1'b1, rand_ctrl(), skid_vals[idx], 1'b1, acc);
      if (acc) idx++;
    end
    checkOutput("stall_all_accepted", 128'(idx), 128'(3));
    repeat (3) applyStimulus(COND_LOAD, 1'b0, '0, '0, 1'b1, acc);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      c = COND_FLUSH;
      else if (r < 7) c = COND_LOAD;
      else if (r < 9) c = COND_HOLD;
      else            c = 2'd3;
      applyStimulus(c, 1'($urandom_range(0, 1)), rand_ctrl(), rand_data(),
                    1'($urandom_range(0, 3) != 0), acc);
    end

    // Drain and confirm every accepted beat came out
    for (int i = 0; i < 8 && model_q.size() != 0; i++) applyStimulus(COND_LOAD, 1'b0, '0, '0, 1'b1, acc);
    @(negedge clk);
    #1;
    checkOutput("sb_drained", 128'(sb_q.size()), 128'(0));

    // Reset in the middle of a cycle with a live beat
    idx = 0;
    for (int i = 0; i < 4 && idx == 0; i++) begin
      applyStimulus(COND_LOAD, 1'b1, 4'hC, DATA_W'(32'hBEEF), 1'b1, acc);
      if (acc) idx = 1;
    end
    applyStimulus(COND_LOAD, 1'b0, '0, '0, 1'b0, acc);
    mon_en = 1'b0;
    #2;
    checkOutput("pre_rst_out_valid", 128'(bus.out_valid), 128'(model_q.size() != 0));
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    checkOutput("midrst_out_ctrl", 128'(bus.out_ctrl), 128'(0));
    checkOutput("midrst_out_data", 128'(bus.out_data), 128'(0));
    checkOutput("midrst_hold_cnt", 128'(bus.hold_cnt), 128'(0));
    checkOutput("midrst_hold_cnt_2", 128'(bus2.hold_cnt), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    resetModel();

    // Recovery after reset
    for (int i = 0; i < 4; i++) applyStimulus(COND_LOAD, 1'b1, rand_ctrl(), rand_data(), 1'b1, acc);
    repeat (2) applyStimulus(COND_LOAD, 1'b0, '0, '0, 1'b1, acc);
    @(negedge clk);
    #1;
    checkOutput("sb_final_empty", 128'(sb_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
